// File: rtl/ss_hotkey.sv
// ---------------------------------------------------------------------------
// ss_hotkey
//
// Snoops CPU accesses to the controller port at $4016 and rebuilds the
// controller-1 button byte from the serial read stream. Each completed byte is
// compared against the save/load/menu hot-key combos. A combo that newly
// matches raises a latched request for the save-state engine. The block also
// debounces an external in-game-menu button, which acts as a second source of
// menu requests.
//
// Parameters
//   DEBOUNCE_CYC  clk cycles the external button must be stable before a new
//                 level is accepted.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   cpu_m2            CPU M2 phase (asynchronous to clk)
//   cpu_addr[15:0]    CPU address bus
//   cpu_rw            1 = read, 0 = write
//   cpu_dat[7:0]      CPU data bus (bit 0 = serial button bit / strobe)
//   ss_key_save[7:0]  save combo, 8'h00 disables
//   ss_key_load[7:0]  load combo, 8'h00 disables
//   ss_key_menu[7:0]  menu combo, 8'h00 disables
//   ct_ss_on          master enable for all requests
//   ct_ss_btn         enables the external button path
//   ss_btn            raw external button, active high, asynchronous
//   req_ack           one-cycle pulse that clears all requests
//   joy_state[7:0]    last complete button byte (bit 0 = A ... bit 7 = Right)
//   req_save          latched save request
//   req_load          latched load request
//   req_menu          latched menu request
// ---------------------------------------------------------------------------
module ss_hotkey #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_m2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dat,
  input  logic [7:0]  ss_key_save,
  input  logic [7:0]  ss_key_load,
  input  logic [7:0]  ss_key_menu,
  input  logic        ct_ss_on,
  input  logic        ct_ss_btn,
  input  logic        ss_btn,
  input  logic        req_ack,
  output logic [7:0]  joy_state,
  output logic        req_save,
  output logic        req_load,
  output logic        req_menu
);

  localparam logic [15:0] JOY_ADDR = 16'h4016;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_SHIFT
  } shift_state_e;

  // -------------------------------------------------------------------------
  // M2 capture
  // -------------------------------------------------------------------------
  logic        m2_s1, m2_s2, m2_s3;
  logic        bus_ev;
  logic [15:0] addr_q;
  logic        rw_q;
  logic        dat0_q;

  // Only the serial bit of the data bus is meaningful for this port.
  logic unused_dat;
  assign unused_dat = ^cpu_dat[7:1];

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_s1  <= 1'b0;
      m2_s2  <= 1'b0;
      m2_s3  <= 1'b0;
      bus_ev <= 1'b0;
    end else begin
      m2_s1  <= cpu_m2;
      m2_s2  <= m2_s1;
      m2_s3  <= m2_s2;
      // Registered falling-edge detect: lands three edges after the pin falls.
      bus_ev <= m2_s3 & ~m2_s2;
    end
  end

  // Bus fields follow the bus while M2 is high and freeze once it drops, so
  // the values seen at bus_ev are the last ones of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 16'h0000;
      rw_q   <= 1'b1;
      dat0_q <= 1'b0;
    end else if (m2_s2) begin
      addr_q <= cpu_addr;
      rw_q   <= cpu_rw;
      dat0_q <= cpu_dat[0];
    end
  end

  logic joy_wr, joy_rd;
  assign joy_wr = bus_ev && (addr_q == JOY_ADDR) && !rw_q;
  assign joy_rd = bus_ev && (addr_q == JOY_ADDR) &&  rw_q;

  // -------------------------------------------------------------------------
  // Shift FSM
  // -------------------------------------------------------------------------
  shift_state_e state, state_nx;
  logic [7:0]   shreg, shreg_nx;
  logic [2:0]   cnt, cnt_nx;
  logic [7:0]   joy_nx;
  logic         frame_done, frame_done_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= 8'h00;
      cnt        <= 3'd0;
      joy_state  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      joy_state  <= joy_nx;
      frame_done <= frame_done_nx;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    cnt_nx        = cnt;
    joy_nx        = joy_state;
    frame_done_nx = 1'b0;

    if (joy_wr && dat0_q) begin
      // Strobe high restarts the sequence from any state and throws away a
      // partially shifted byte; joy_state is left untouched.
      state_nx = ST_STROBE;
      shreg_nx = 8'h00;
      cnt_nx   = 3'd0;
    end else begin
      unique case (state)
        ST_STROBE: begin
          if (joy_wr) begin
            state_nx = ST_SHIFT;
            cnt_nx   = 3'd0;
          end
        end
        ST_SHIFT: begin
          if (joy_rd) begin
            shreg_nx[cnt] = dat0_q;
            if (cnt == 3'd7) begin
              joy_nx        = shreg_nx;
              frame_done_nx = 1'b1;
              state_nx      = ST_IDLE;
              cnt_nx        = 3'd0;
            end else begin
              cnt_nx = cnt + 3'd1;
            end
          end
        end
        default: ;  // ST_IDLE: reads are ignored until the next strobe
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Hot-key matching (evaluated on frame_done against the new joy_state)
  // -------------------------------------------------------------------------
  logic m_save, m_load, m_menu;
  logic prev_m_save, prev_m_load, prev_m_menu;

  assign m_save = (ss_key_save != 8'h00) && (joy_state == ss_key_save);
  assign m_load = (ss_key_load != 8'h00) && (joy_state == ss_key_load);
  assign m_menu = (ss_key_menu != 8'h00) && (joy_state == ss_key_menu);

  // History advances on every frame, even when the request latch is busy or
  // disabled, so a held combo cannot fire later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_m_save <= 1'b0;
      prev_m_load <= 1'b0;
      prev_m_menu <= 1'b0;
    end else if (frame_done) begin
      prev_m_save <= m_save;
      prev_m_load <= m_load;
      prev_m_menu <= m_menu;
    end
  end

  logic key_save_ev, key_load_ev, key_menu_ev;
  assign key_save_ev = frame_done && m_save && !prev_m_save;
  assign key_load_ev = frame_done && m_load && !prev_m_load;
  assign key_menu_ev = frame_done && m_menu && !prev_m_menu;

  // -------------------------------------------------------------------------
  // External button: synchronizer + debounce
  // -------------------------------------------------------------------------
  logic        btn_s1, btn_s2;
  logic        btn_db, btn_db_d;
  logic [15:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= 16'h0000;
    end else begin
      btn_s1   <= ss_btn;
      btn_s2   <= btn_s1;
      btn_db_d <= btn_db;
      // Count only while the input differs from the accepted level; any
      // change back to the accepted level restarts the count.
      if (btn_s2 != btn_db) begin
        if (db_cnt == DEBOUNCE_CYC - 16'd1) begin
          btn_db <= btn_s2;
          db_cnt <= 16'h0000;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= 16'h0000;
      end
    end
  end

  logic btn_menu_ev;
  assign btn_menu_ev = ct_ss_btn && btn_db && !btn_db_d;

  // -------------------------------------------------------------------------
  // Request latch
  // -------------------------------------------------------------------------
  logic menu_ev, any_req;
  assign menu_ev = key_menu_ev || btn_menu_ev;
  assign any_req = req_save || req_load || req_menu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_save <= 1'b0;
      req_load <= 1'b0;
      req_menu <= 1'b0;
    end else if (!ct_ss_on || req_ack) begin
      // Disable and ack both win over any event arriving in the same cycle.
      req_save <= 1'b0;
      req_load <= 1'b0;
      req_menu <= 1'b0;
    end else if (!any_req) begin
      // One request per event, menu > save > load.
      if (menu_ev) begin
        req_menu <= 1'b1;
      end else if (key_save_ev) begin
        req_save <= 1'b1;
      end else if (key_load_ev) begin
        req_load <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ss_hotkey.sv
// ---------------------------------------------------------------------------
// tb_ss_hotkey: directed bench for ss_hotkey (DEBOUNCE_CYC = 8).
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge as well, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ss_hotkey;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dat;
  logic [7:0]  ss_key_save, ss_key_load, ss_key_menu;
  logic        ct_ss_on, ct_ss_btn, ss_btn, req_ack;
  logic [7:0]  joy_state;
  logic        req_save, req_load, req_menu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ss_hotkey #(.DEBOUNCE_CYC(16'd8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_m2      (cpu_m2),
    .cpu_addr    (cpu_addr),
    .cpu_rw      (cpu_rw),
    .cpu_dat     (cpu_dat),
    .ss_key_save (ss_key_save),
    .ss_key_load (ss_key_load),
    .ss_key_menu (ss_key_menu),
    .ct_ss_on    (ct_ss_on),
    .ct_ss_btn   (ct_ss_btn),
    .ss_btn      (ss_btn),
    .req_ack     (req_ack),
    .joy_state   (joy_state),
    .req_save    (req_save),
    .req_load    (req_load),
    .req_menu    (req_menu)
  );

  // Drives one bus cycle and returns at the falling clock edge where M2 drops.
  task automatic bus_begin(input logic [15:0] a, input logic rw, input logic d0);
    @(negedge clk);
    cpu_addr = a;
    cpu_rw   = rw;
    cpu_dat  = {7'b1010101, d0};
    cpu_m2   = 1'b1;
    repeat (3) @(negedge clk);
    cpu_m2 = 1'b0;
  endtask

  task automatic bus_access(input logic [15:0] a, input logic rw, input logic d0);
    bus_begin(a, rw, d0);
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    bus_access(16'h4016, 1'b0, 1'b1);
    bus_access(16'h4016, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bus_access(16'h4016, 1'b1, b[i]);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_m2 = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_dat = 8'h00;
    ss_key_save = 8'h00; ss_key_load = 8'h00; ss_key_menu = 8'h00;
    ct_ss_on = 1'b0; ct_ss_btn = 1'b0; ss_btn = 1'b0; req_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (joy_state !== 8'h00) begin errors++; $display("FAIL reset_joy got %h exp 00", joy_state); end
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b000) begin
      errors++; $display("FAIL reset_req got %b exp 000", {req_save, req_load, req_menu});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    ss_key_save = 8'h09; ct_ss_on = 1'b1;
    bus_access(16'h4016, 1'b0, 1'b1);
    bus_access(16'h4016, 1'b0, 1'b0);
    // Bits 1,0,0,1,0,0,0 then a final 0 on the eighth read.
    bus_access(16'h4016, 1'b1, 1'b1);
    bus_access(16'h4016, 1'b1, 1'b0);
    bus_access(16'h4016, 1'b1, 1'b0);
    bus_access(16'h4016, 1'b1, 1'b1);
    bus_access(16'h4016, 1'b1, 1'b0);
    bus_access(16'h4016, 1'b1, 1'b0);
    bus_access(16'h4016, 1'b1, 1'b0);
    checks++;
    if (joy_state !== 8'h00) begin errors++; $display("FAIL basic_joy_before_last got %h exp 00", joy_state); end
    bus_begin(16'h4016, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (joy_state !== 8'h09) begin errors++; $display("FAIL basic_joy got %h exp 09", joy_state); end
    checks++;
    if (req_save !== 1'b0) begin errors++; $display("FAIL basic_save_early got %b exp 0", req_save); end
    @(negedge clk);
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b100) begin
      errors++; $display("FAIL basic_req got %b exp 100", {req_save, req_load, req_menu});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold_repress();
    // A request is already pending from the basic frame; holding does not add.
    send_frame(8'h09);
    pulse_ack();
    checks++;
    if (req_save !== 1'b0) begin errors++; $display("FAIL hold_ack got %b exp 0", req_save); end
    send_frame(8'h09);
    checks++;
    if (req_save !== 1'b0) begin errors++; $display("FAIL hold_no_refire got %b exp 0", req_save); end
    send_frame(8'h00);
    checks++;
    if (req_save !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", req_save); end
    send_frame(8'h09);
    checks++;
    if (req_save !== 1'b1) begin errors++; $display("FAIL repress_save got %b exp 1", req_save); end
    pulse_ack();
  endtask

  task automatic test_abort();
    bus_access(16'h4016, 1'b0, 1'b1);
    bus_access(16'h4016, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bus_access(16'h4016, 1'b1, 1'b1);
    bus_access(16'h4016, 1'b0, 1'b1);
    checks++;
    if (joy_state !== 8'h09) begin errors++; $display("FAIL abort_keep got %h exp 09", joy_state); end
    bus_access(16'h4016, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      // Reads of $4017 and $4000 in the middle must not shift anything.
      if (i == 3) begin
        bus_access(16'h4017, 1'b1, 1'b1);
        bus_access(16'h4000, 1'b1, 1'b1);
      end
      bus_access(16'h4016, 1'b1, (i >= 6) ? 1'b1 : 1'b0);
    end
    checks++;
    if (joy_state !== 8'hC0) begin errors++; $display("FAIL abort_joy got %h exp c0", joy_state); end
    // A read in IDLE is ignored.
    bus_access(16'h4016, 1'b1, 1'b1);
    checks++;
    if (joy_state !== 8'hC0) begin errors++; $display("FAIL idle_read got %h exp c0", joy_state); end
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b000) begin
      errors++; $display("FAIL abort_req got %b exp 000", {req_save, req_load, req_menu});
    end
  endtask

  task automatic test_priority();
    ss_key_save = 8'h30; ss_key_menu = 8'h30; ss_key_load = 8'h00;
    send_frame(8'h30);
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b001) begin
      errors++; $display("FAIL prio_req got %b exp 001", {req_save, req_load, req_menu});
    end
    pulse_ack();
    ss_key_save = 8'h00; ss_key_menu = 8'h00;
    send_frame(8'h00);
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b000) begin
      errors++; $display("FAIL zero_keys got %b exp 000", {req_save, req_load, req_menu});
    end
  endtask

  task automatic test_gating();
    ss_key_load = 8'h55;
    ct_ss_on = 1'b0;
    send_frame(8'h55);
    checks++;
    if (req_load !== 1'b0) begin errors++; $display("FAIL gate_off got %b exp 0", req_load); end
    ct_ss_on = 1'b1;
    send_frame(8'h00);
    send_frame(8'h55);
    checks++;
    if ({req_save, req_load, req_menu} !== 3'b010) begin
      errors++; $display("FAIL gate_load got %b exp 010", {req_save, req_load, req_menu});
    end
    @(negedge clk);
    ct_ss_on = 1'b0;
    @(negedge clk);
    checks++;
    if (req_load !== 1'b0) begin errors++; $display("FAIL gate_clear got %b exp 0", req_load); end
    ct_ss_on = 1'b1;
    ss_key_load = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_button();
    ct_ss_btn = 1'b1;
    @(negedge clk);
    ss_btn = 1'b1;
    repeat (5) @(negedge clk);
    ss_btn = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (req_menu !== 1'b0) begin errors++; $display("FAIL btn_glitch got %b exp 0", req_menu); end
    ss_btn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (req_menu !== 1'b0) begin errors++; $display("FAIL btn_early got %b exp 0", req_menu); end
    @(negedge clk);
    checks++;
    if (req_menu !== 1'b1) begin errors++; $display("FAIL btn_menu got %b exp 1", req_menu); end
    repeat (9) @(negedge clk);
    ss_btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({joy_state, req_save, req_load, req_menu} !== 11'h000) begin
      errors++;
      $display("FAIL async_rst got %h/%b exp 00/000", joy_state, {req_save, req_load, req_menu});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_repress();
    test_abort();
    test_priority();
    test_gating();
    test_button();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_hotkey.md
# ss_hotkey

Snoops CPU accesses to the controller port at $4016, rebuilds the controller-1 button byte, and matches it against the save-state hot-key bytes held in the system configuration registers. On a match it raises a latched save, load or menu request for the in-game-menu / save-state engine. It also debounces the external in-game-menu button. The block sits directly downstream of the system configuration register file and consumes its `ss_key_*` and control fields.

## Interface
- `DEBOUNCE_CYC`, default 16'd50000: `clk` cycles the external button must stay stable before a level change is accepted.
- `clk` in 1: system clock; must be at least 4x the M2 frequency.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_m2` in 1: CPU M2 phase, asynchronous to `clk`.
- `cpu_addr` in 16: CPU address bus.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_dat` in 8: CPU data bus; bit 0 carries the serial button bit on $4016 reads, or the strobe on writes.
- `ss_key_save` in 8: save hot-key combo; 8'h00 disables it.
- `ss_key_load` in 8: load hot-key combo; 8'h00 disables it.
- `ss_key_menu` in 8: menu hot-key combo; 8'h00 disables it.
- `ct_ss_on` in 1: master enable for all requests.
- `ct_ss_btn` in 1: enables the external button path.
- `ss_btn` in 1: raw external button, active high, asynchronous.
- `req_ack` in 1: single-cycle pulse from the consumer that clears all requests.
- `joy_state` out 8: last complete button byte. Bit order is A, B, Select, Start, Up, Down, Left, Right (bit 0 = A); 1 = pressed.
- `req_save` out 1: latched save request.
- `req_load` out 1: latched load request.
- `req_menu` out 1: latched menu request.

## Operation
- **M2 capture**
  - `cpu_m2` passes through a 2-flop synchronizer.
  - A falling edge of the synchronized M2 makes a one-cycle `bus_ev`.
  - `cpu_addr`, `cpu_rw` and `cpu_dat` are registered every `clk` while synchronized M2 is high. The values held at `bus_ev` are the ones used.
- **Shift FSM**, states IDLE, STROBE, SHIFT:
  - Write to $4016 with dat[0]=1: go to STROBE from any state; clear the shift register and `cnt`.
  - Write to $4016 with dat[0]=0 while in STROBE: go to SHIFT with `cnt`=0.
  - Read of $4016 in SHIFT: `shreg[cnt]` <= dat[0], then `cnt`++. On the read with `cnt`=7, `joy_state` <= completed byte, pulse `frame_done`, go to IDLE.
  - Reads of $4016 in IDLE or STROBE are ignored.
  - Reads of $4017 and accesses to any other address are ignored.
  - A strobe write in the middle of SHIFT discards the partial byte; `joy_state` keeps its old value.
- **Matching**, evaluated on `frame_done` against the new byte:
  - `m_x` = (key != 0) && (byte == key), an exact 8-bit compare.
  - `prev_m_x` holds the previous frame's `m_x`.
  - A request fires only on the frame where `m_x` rises 0 to 1. Holding a combo produces one request.
- **External button path**
  - `ss_btn` passes through a 2-flop synchronizer, then a debounce counter of width 16.
  - The counter resets on any input change; the stable level is accepted when the counter reaches `DEBOUNCE_CYC`-1.
  - A rising edge of the debounced level, while `ct_ss_btn`=1, is a menu event.
- **Request latch**
  - Requests are accepted only when `ct_ss_on`=1 and no `req_*` is currently set.
  - Exactly one request is set per event. Priority is menu > save > load, so equal keys raise only the highest-priority one.
  - Events arriving while any `req_*` is set are dropped. `prev_m_x` still updates, so a held combo does not fire after `req_ack`.
  - `req_ack` clears all three requests in the next cycle. If `req_ack` coincides with a new event, the ack wins and the event is dropped.
  - `ct_ss_on`=0 clears any pending request.

## Timing
- Reset values:
  - `joy_state`=8'h00; `req_*`=0.
  - FSM=IDLE, `cnt`=0, `prev_m_*`=0.
  - Debounced level=0, debounce counter=0.
- Latency, measured in `clk` edges:
  - M2 falling pin to `bus_ev`: 3.
  - `bus_ev` to `joy_state` update: 1.
  - `frame_done` to `req_*` high: 1.
  - Total from the 8th read's M2 fall to request: at most 5.
- External button: a press held for `DEBOUNCE_CYC` cycles sets `req_menu` at `DEBOUNCE_CYC`+3 cycles after the pin edge.
- `req_*` outputs are level signals and stay high until `req_ack` or `ct_ss_on`=0.

## Test plan
- **Basic capture:** strobe 1/0, then 8 reads with bits 1,0,0,1,0,0,0,0 -> `joy_state`=8'h09. With `ss_key_save`=8'h09, `req_save`=1 one cycle later; `req_load`=`req_menu`=0.
- **Hold and re-press:** the same byte on 3 consecutive frames -> exactly one `req_save`. After `req_ack`, a frame of 8'h00 followed by 8'h09 -> a second `req_save`.
- **Abort mid-read:** a strobe after 4 reads, then a full read of 8'hC0 -> `joy_state`=8'hC0, with no byte mixing.
- **Priority and disable:** `ss_key_menu`=`ss_key_save`=8'h30 with frame 8'h30 -> only `req_menu`. With all keys 8'h00 and frame 8'h00 -> no request.
- **Gating:** `ct_ss_on`=0 with a matching frame -> no request. Setting `ct_ss_on` low while `req_load` is pending clears it.
- **External button:** with `DEBOUNCE_CYC`=8, a 5-cycle glitch -> nothing; a 20-cycle press with `ct_ss_btn`=1 -> `req_menu` at cycle 11 after the edge. Asserting `rst` while the request is pending -> all outputs 0 immediately.
